xor_keystream_gen: RTL and testbench

Byte-wide LFSR keystream generator that sits directly upstream of the 8-bit XOR cipher stage and supplies its key operand, one byte per accepted transfer. Loads a seed, discards a configurable number of warm-up steps, then presents key bytes under a valid/ready handshake. Encryptor and decryptor instances share one seed and stay byte-aligned because the generator advances only on an accepted transfer.

---
 rtl/xor_keystream_gen.sv | 93 +++++++++
 tb/tb_xor_keystream_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/xor_keystream_gen.sv
// Byte-wide Fibonacci LFSR keystream source with seed load, warm-up discard and valid/ready output.
// Optional macro XOR_KEYGEN_COUNT_EN adds the 16-bit key_count port and accepted-transfer counter.
module xor_keystream_gen #(
  parameter logic [7:0]  DEFAULT_SEED = 8'hA5,
  parameter int unsigned WARMUP       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [7:0]  seed_in,
  input  logic        key_ready,
  output logic        key_valid,
  output logic [7:0]  key_out,
  output logic        busy
`ifdef XOR_KEYGEN_COUNT_EN
  ,
  output logic [15:0] key_count
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WARMUP = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;

  localparam logic [3:0] WARMUP_CNT = 4'(WARMUP);

  logic [1:0] r_state;
  logic [7:0] r_lfsr;
  logic [3:0] r_warmCnt;

  logic       w_fb;
  logic [7:0] w_lfsrNext;
  logic [7:0] w_seed;
  logic       w_accept;

  assign w_fb       = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_lfsrNext = {r_lfsr[6:0], w_fb};
  // An all-zero LFSR would lock up, so a zero seed is replaced by 8'h01.
  assign w_seed     = (seed_in == 8'h00) ? 8'h01 : seed_in;
  assign w_accept   = (r_state == S_RUN) && key_ready;

  assign key_valid = (r_state == S_RUN);
  assign busy      = (r_state == S_WARMUP);
  assign key_out   = r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_lfsr    <= DEFAULT_SEED;
      r_warmCnt <= 4'd0;
    end else if (seed_load) begin
      r_lfsr    <= w_seed;
      r_warmCnt <= WARMUP_CNT;
      r_state   <= (WARMUP_CNT == 4'd0) ? S_RUN : S_WARMUP;
    end else begin
      case (r_state)
        S_WARMUP: begin
          r_lfsr    <= w_lfsrNext;
          r_warmCnt <= r_warmCnt - 4'd1;
          if (r_warmCnt == 4'd1) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_lfsr <= w_lfsrNext;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

`ifdef XOR_KEYGEN_COUNT_EN
  logic [15:0] r_keyCount;

  // A reload restarts the count even if a transfer is offered in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_keyCount <= 16'd0;
    end else if (seed_load) begin
      r_keyCount <= 16'd0;
    end else if (w_accept) begin
      r_keyCount <= r_keyCount + 16'd1;
    end
  end

  assign key_count = r_keyCount;
`endif

endmodule

// File: tb/tb_xor_keystream_gen.sv
// Self-checking bench for xor_keystream_gen: three instances (WARMUP 0, 2, 4) share one stimulus stream.
// Key_count checks are compiled in when XOR_KEYGEN_COUNT_EN is defined.
module tb_xor_keystream_gen;

  typedef struct {
    logic       load;
    logic [7:0] seed;
    logic       ready;
    logic       v0;
    logic [7:0] k0;
    logic       v2;
    logic       b2;
    logic [7:0] k2;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       seed_load;
  logic [7:0] seed_in;
  logic       key_ready;

  logic [2:0] kv;
  logic [2:0] bz;
  logic [7:0] ko [3];
`ifdef XOR_KEYGEN_COUNT_EN
  logic [15:0] kc [3];
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] mS      [3];
  int         mLeft   [3];
  bit         mLoaded [3];
  int         mCnt    [3];

  vec_t tbl [10];

  always #5 clk = ~clk;

  xor_keystream_gen #(.DEFAULT_SEED(8'hA5), .WARMUP(0)) u0 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in), .key_ready(key_ready),
    .key_valid(kv[0]), .key_out(ko[0]), .busy(bz[0])
`ifdef XOR_KEYGEN_COUNT_EN
    , .key_count(kc[0])
`endif
  );

  xor_keystream_gen #(.DEFAULT_SEED(8'hA5), .WARMUP(2)) u2 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in), .key_ready(key_ready),
    .key_valid(kv[1]), .key_out(ko[1]), .busy(bz[1])
`ifdef XOR_KEYGEN_COUNT_EN
    , .key_count(kc[1])
`endif
  );

  xor_keystream_gen #(.DEFAULT_SEED(8'hA5), .WARMUP(4)) u4 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in), .key_ready(key_ready),
    .key_valid(kv[2]), .key_out(ko[2]), .busy(bz[2])
`ifdef XOR_KEYGEN_COUNT_EN
    , .key_count(kc[2])
`endif
  );

  function automatic int warmOf(int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 4);
  endfunction

  // Shift left one place; the new low bit is the parity of tap positions 8/6/5/4 (mask B8).
  function automatic logic [7:0] lfsrAdv(logic [7:0] s);
    int v;
    v = ((int'(s) * 2) % 256) + ($countones(s & 8'hB8) % 2);
    return 8'(v);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      mS[i]      = 8'hA5;
      mLeft[i]   = 0;
      mLoaded[i] = 1'b0;
      mCnt[i]    = 0;
    end
  endtask

  task automatic modelUpdate();
    bit valid;
    for (int i = 0; i < 3; i++) begin
      valid = mLoaded[i] && (mLeft[i] == 0);
      if (seed_load) begin
        mS[i]      = (seed_in == 8'h00) ? 8'h01 : seed_in;
        mLeft[i]   = warmOf(i);
        mLoaded[i] = 1'b1;
        mCnt[i]    = 0;
      end else if (mLoaded[i] && mLeft[i] > 0) begin
        mS[i]    = lfsrAdv(mS[i]);
        mLeft[i] = mLeft[i] - 1;
      end else if (valid && key_ready) begin
        mS[i]   = lfsrAdv(mS[i]);
        mCnt[i] = (mCnt[i] + 1) % 65536;
      end
    end
  endtask

  task automatic checkVal(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(logic load, logic [7:0] seed, logic ready);
    seed_load = load;
    seed_in   = seed;
    key_ready = ready;
  endtask

  task automatic step();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic checkOutput(string tag);
    for (int i = 0; i < 3; i++) begin
      checkVal($sformatf("%s valid[%0d]", tag, i), 16'(kv[i]), 16'(mLoaded[i] && mLeft[i] == 0));
      checkVal($sformatf("%s busy[%0d]", tag, i), 16'(bz[i]), 16'(mLoaded[i] && mLeft[i] > 0));
      checkVal($sformatf("%s key[%0d]", tag, i), 16'(ko[i]), 16'(mS[i]));
`ifdef XOR_KEYGEN_COUNT_EN
      checkVal($sformatf("%s count[%0d]", tag, i), kc[i], 16'(mCnt[i]));
`endif
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h4A, 1'b0, 1'b1, 8'h4A};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h95, 1'b1, 1'b0, 8'h95};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h2A, 1'b1, 1'b0, 8'h2A};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h2A, 1'b1, 1'b0, 8'h2A};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h54, 1'b1, 1'b0, 8'h54};
    tbl[6] = '{1'b1, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 8'h01};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 8'h02};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 8'h04};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 1'b1, 1'b0, 8'h08};

    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset");
    rst_n = 1'b1;

    $display("[TB] reset hold, no load");
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 4; c++) begin
      step();
      checkOutput("idle");
      checkVal("idle key u0", 16'(ko[0]), 16'h00A5);
      checkVal("idle valid u0", 16'(kv[0]), 16'h0000);
    end

    $display("[TB] vector table");
    for (int r = 0; r < 10; r++) begin
      applyStimulus(tbl[r].load, tbl[r].seed, tbl[r].ready);
      step();
      checkOutput($sformatf("row%0d", r));
      checkVal($sformatf("row%0d v0", r), 16'(kv[0]), 16'(tbl[r].v0));
      checkVal($sformatf("row%0d k0", r), 16'(ko[0]), 16'(tbl[r].k0));
      checkVal($sformatf("row%0d v2", r), 16'(kv[1]), 16'(tbl[r].v2));
      checkVal($sformatf("row%0d b2", r), 16'(bz[1]), 16'(tbl[r].b2));
      checkVal($sformatf("row%0d k2", r), 16'(ko[1]), 16'(tbl[r].k2));
`ifdef XOR_KEYGEN_COUNT_EN
      if (r == 5) checkVal("row5 count u0", kc[0], 16'd4);
`endif
    end

    $display("[TB] backpressure");
    applyStimulus(1'b1, 8'hA5, 1'b0);
    step();
    applyStimulus(1'b0, 8'h00, 1'b1);
    step();
    checkVal("bp start key", 16'(ko[0]), 16'h004A);
    applyStimulus(1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step();
      checkOutput("bp hold");
      checkVal("bp hold key", 16'(ko[0]), 16'h004A);
      checkVal("bp hold valid", 16'(kv[0]), 16'h0001);
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    step();
    checkOutput("bp release");
    checkVal("bp release key", 16'(ko[0]), 16'h0095);

    $display("[TB] load during handshake");
    applyStimulus(1'b1, 8'h3C, 1'b1);
    step();
    checkOutput("load+hs");
    checkVal("load+hs key", 16'(ko[0]), 16'h003C);
`ifdef XOR_KEYGEN_COUNT_EN
    checkVal("load+hs count", kc[0], 16'd0);
`endif

    $display("[TB] reset mid warm-up");
    applyStimulus(1'b1, 8'h5A, 1'b0);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0);
    step();
    checkVal("warm busy u4", 16'(bz[2]), 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async reset");
    checkVal("async reset key u4", 16'(ko[2]), 16'h00A5);
    checkVal("async reset busy u4", 16'(bz[2]), 16'h0000);
    #2;
    rst_n = 1'b1;
    step();
    checkOutput("after reset");

    $display("[TB] random stimulus");
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 15) == 0,
                    ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                    $urandom_range(0, 3) != 0);
      step();
      checkOutput("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
